// File: rtl/alu_pkg.sv
// +-----------------------------------------------------------------------+
// | alu_pkg : op/state encodings and the 1-bit ALU cell for the serial ALU |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_t;

  typedef logic [1:0] alu_state_t;

  localparam alu_state_t C_ST_IDLE = 2'd0;
  localparam alu_state_t C_ST_CALC = 2'd1;
  localparam alu_state_t C_ST_DONE = 2'd2;

  // Returns {carry_out, sum}; b must already be inverted by the caller for SUB.
  function automatic logic [1:0] alu_cell(input logic a, input logic b,
                                          input logic cin, input alu_op_t op);
    logic [1:0] r;
    case (op)
      OP_NOR:  r = {1'b0, ~(a | b)};
      OP_XOR:  r = {1'b0, a ^ b};
      default: r = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endcase
    return r;
  endfunction

  function automatic logic dw_is_legal(input int dw);
    return (dw == 1) || (dw == 2) || (dw == 4) || (dw == 8) ||
           (dw == 16) || (dw == 32) || (dw == 64);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_digit.sv
// +-----------------------------------------------------------------------+
// | alu_digit : combinational DW-bit ALU slice, ripple chain of 1-bit cells|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module alu_digit
  import alu_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  alu_op_t       op,
  output logic [DW-1:0] s,
  output logic          cout
);

  logic [DW-1:0] w_b_eff;
  logic          w_carry;
  logic [1:0]    w_cell;

  assign w_b_eff = (op == OP_SUB) ? ~b : b;

  // Carry kept in a single variable so the ripple does not loop through a vector.
  always_comb begin
    w_carry = cin;
    w_cell  = 2'b00;
    s       = '0;
    for (int i = 0; i < DW; i++) begin
      w_cell  = alu_cell(a[i], w_b_eff[i], w_carry, op);
      s[i]    = w_cell[0];
      w_carry = w_cell[1];
    end
  end

  assign cout = ((op == OP_ADD) || (op == OP_SUB)) ? w_carry : 1'b0;

endmodule

`default_nettype wire

// File: rtl/alu64bit_serial.sv
// +-----------------------------------------------------------------------+
// | alu64bit_serial : 64-bit NOR/XOR/ADD/SUB ALU, DW result bits per clock |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module alu64bit_serial
  import alu_pkg::*;
#(
  parameter  int DW    = 1,
  localparam int NSTEP = 64 / DW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] s,
  output logic        cout,
  output logic        busy
);

  localparam int            KW       = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(NSTEP - 1);

  generate
    if (!dw_is_legal(DW)) begin : g_bad_dw
      $error("alu64bit_serial: DW must be one of 1,2,4,8,16,32,64");
    end
  endgenerate

  alu_state_t    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [63:0]   a_q, a_d;
  logic [63:0]   b_q, b_d;
  alu_op_t       op_q, op_d;
  logic [63:0]   s_q, s_d;
  logic          cout_q, cout_d;

  logic [5:0]    w_base;
  logic [DW-1:0] w_dig_s;
  logic          w_dig_cout;

  assign w_base = 6'(k_q * DW);

  alu_digit #(.DW(DW)) u_digit (
    .a    (a_q[w_base +: DW]),
    .b    (b_q[w_base +: DW]),
    .cin  (carry_q),
    .op   (op_q),
    .s    (w_dig_s),
    .cout (w_dig_cout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      C_ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = alu_op_t'(op);
          carry_d = cin;
          k_d     = '0;
          state_d = C_ST_CALC;
        end
      end
      C_ST_CALC: begin
        s_d[w_base +: DW] = w_dig_s;
        carry_d           = w_dig_cout;
        k_d               = k_q + 1'b1;
        if (k_q == C_K_LAST) begin
          cout_d  = w_dig_cout;
          state_d = C_ST_DONE;
        end
      end
      C_ST_DONE: begin
        if (out_ready) begin
          state_d = C_ST_IDLE;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= C_ST_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOR;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == C_ST_IDLE);
  assign out_valid = (state_q == C_ST_DONE);
  assign busy      = (state_q != C_ST_IDLE);
  assign s         = s_q;
  assign cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_alu64bit_serial.sv
// +-----------------------------------------------------------------------+
// | tb_alu64bit_serial : DW=1/8/64 instances against a plain-arithmetic ref|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_alu64bit_serial;
  import alu_pkg::*;

  localparam int NU = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_v  [NU];
  logic        in_ready_v  [NU];
  logic [63:0] a_v         [NU];
  logic [63:0] b_v         [NU];
  logic        cin_v       [NU];
  logic [1:0]  op_v        [NU];
  logic        out_valid_v [NU];
  logic        out_ready_v [NU];
  logic [63:0] s_v         [NU];
  logic        cout_v      [NU];
  logic        busy_v      [NU];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu64bit_serial #(.DW(1)) u_dut_dw1 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .op(op_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .s(s_v[0]), .cout(cout_v[0]), .busy(busy_v[0]));

  alu64bit_serial #(.DW(8)) u_dut_dw8 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .op(op_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .s(s_v[1]), .cout(cout_v[1]), .busy(busy_v[1]));

  alu64bit_serial #(.DW(64)) u_dut_dw64 (
    .clk(clk), .rst(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .op(op_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .s(s_v[2]), .cout(cout_v[2]), .busy(busy_v[2]));

  task automatic chk_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nstep_of(input int u);
    return (u == 0) ? 64 : ((u == 1) ? 8 : 1);
  endfunction

  // Reference result as {cout, s}.
  function automatic logic [64:0] ref_alu(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin);
    case (op)
      2'b00:   return {1'b0, ~(a | b)};
      2'b01:   return {1'b0, a ^ b};
      2'b10:   return {1'b0, a} + {1'b0, b} + {64'd0, cin};
      default: return {1'b0, a} + {1'b0, ~b} + {64'd0, cin};
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_op(input int u, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic cin, input int hold);
    logic [64:0] exp;
    int lat;
    exp = ref_alu(op, a, b, cin);
    @(negedge clk);
    chk_eq("in_ready_idle", {64'd0, in_ready_v[u]}, 65'd1);
    in_valid_v[u]  = 1'b1;
    a_v[u]         = a;
    b_v[u]         = b;
    cin_v[u]       = cin;
    op_v[u]        = op;
    out_ready_v[u] = 1'b0;
    @(posedge clk);
    #1;
    in_valid_v[u] = 1'b0;
    a_v[u]        = rand64();
    b_v[u]        = rand64();
    cin_v[u]      = 1'($urandom);
    op_v[u]       = 2'($urandom);
    lat = 0;
    while (!out_valid_v[u] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      a_v[u] = rand64();
    end
    chk_eq("latency", 65'(lat), 65'(nstep_of(u)));
    chk_eq("result", {cout_v[u], s_v[u]}, exp);
    chk_eq("in_ready_done", {64'd0, in_ready_v[u]}, 65'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid_v[u] = 1'b1;
      a_v[u]        = rand64();
      @(posedge clk);
      #1;
      chk_eq("hold_valid", {64'd0, out_valid_v[u]}, 65'd1);
      chk_eq("hold_result", {cout_v[u], s_v[u]}, exp);
      chk_eq("hold_in_ready", {64'd0, in_ready_v[u]}, 65'd0);
    end
    @(negedge clk);
    in_valid_v[u]  = 1'b0;
    out_ready_v[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[u] = 1'b0;
    chk_eq("idle_valid", {64'd0, out_valid_v[u]}, 65'd0);
    chk_eq("idle_busy", {64'd0, busy_v[u]}, 65'd0);
    chk_eq("idle_result_held", {cout_v[u], s_v[u]}, exp);
  endtask

  task automatic back_to_back(input int u);
    logic [63:0] ra [2];
    logic [63:0] rb [2];
    logic [1:0]  rop[2];
    logic        rc [2];
    int acc[2];
    int vld[2];
    int fo_e, na, nv, cyc;
    logic fi, fo;
    for (int i = 0; i < 2; i++) begin
      ra[i] = rand64(); rb[i] = rand64(); rop[i] = 2'($urandom); rc[i] = 1'($urandom);
      acc[i] = 0; vld[i] = 0;
    end
    fo_e = -1; na = 0; nv = 0; cyc = 0;
    @(negedge clk);
    out_ready_v[u] = 1'b1;
    in_valid_v[u]  = 1'b1;
    a_v[u] = ra[0]; b_v[u] = rb[0]; op_v[u] = rop[0]; cin_v[u] = rc[0];
    while (nv < 2 && cyc < 400) begin
      fi = in_valid_v[u] && in_ready_v[u];
      fo = out_valid_v[u] && out_ready_v[u];
      @(posedge clk);
      cyc++;
      if (fo && nv == 1) fo_e = cyc;
      #1;
      if (fi && na < 2) begin
        acc[na] = cyc;
        na++;
        if (na < 2) begin
          a_v[u] = ra[1]; b_v[u] = rb[1]; op_v[u] = rop[1]; cin_v[u] = rc[1];
        end else begin
          in_valid_v[u] = 1'b0;
        end
      end
      if (out_valid_v[u] && nv < 2) begin
        vld[nv] = cyc;
        chk_eq("b2b_result", {cout_v[u], s_v[u]}, ref_alu(rop[nv], ra[nv], rb[nv], rc[nv]));
        nv++;
      end
      @(negedge clk);
    end
    chk_eq("b2b_count", 65'(nv), 65'd2);
    chk_eq("b2b_lat0", 65'(vld[0] - acc[0]), 65'(nstep_of(u)));
    chk_eq("b2b_lat1", 65'(vld[1] - acc[1]), 65'(nstep_of(u)));
    chk_eq("b2b_gap", 65'(acc[1]), 65'(fo_e + 1));
    @(posedge clk);
    #1;
    out_ready_v[u] = 1'b0;
    in_valid_v[u]  = 1'b0;
  endtask

  initial begin
    logic seen;
    for (int u = 0; u < NU; u++) begin
      in_valid_v[u] = 1'b0; out_ready_v[u] = 1'b0;
      a_v[u] = '0; b_v[u] = '0; cin_v[u] = 1'b0; op_v[u] = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      chk_eq("rst_result", {cout_v[u], s_v[u]}, 65'd0);
      chk_eq("rst_valid", {64'd0, out_valid_v[u]}, 65'd0);
      chk_eq("rst_busy", {64'd0, busy_v[u]}, 65'd0);
      chk_eq("rst_in_ready", {64'd0, in_ready_v[u]}, 65'd1);
    end
    rst_n = 1'b1;

    do_op(0, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    chk_eq("add_wrap_const", {cout_v[0], s_v[0]}, {1'b1, 64'd0});
    do_op(0, OP_SUB, 64'd5, 64'd3, 1'b1, 0);
    chk_eq("sub_pos_const", {cout_v[0], s_v[0]}, {1'b1, 64'd2});
    do_op(0, OP_SUB, 64'd3, 64'd5, 1'b1, 0);
    chk_eq("sub_neg_const", {cout_v[0], s_v[0]}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    do_op(1, OP_NOR, 64'd0, 64'h00FF_00FF_00FF_00FF, 1'b1, 0);
    chk_eq("nor_const", {cout_v[1], s_v[1]}, {1'b0, 64'hFF00_FF00_FF00_FF00});
    do_op(1, OP_XOR, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0);
    chk_eq("xor_same_const", {cout_v[1], s_v[1]}, 65'd0);
    do_op(1, OP_ADD, rand64(), rand64(), 1'b1, 10);

    // Abort a DW=1 operation mid-flight.
    @(negedge clk);
    in_valid_v[0] = 1'b1; a_v[0] = rand64(); b_v[0] = rand64(); op_v[0] = OP_ADD; cin_v[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_eq("abort_result", {cout_v[0], s_v[0]}, 65'd0);
    chk_eq("abort_valid", {64'd0, out_valid_v[0]}, 65'd0);
    chk_eq("abort_busy", {64'd0, busy_v[0]}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid_v[0]) seen = 1'b1;
    end
    chk_eq("abort_no_valid", {64'd0, seen}, 65'd0);
    do_op(0, OP_ADD, 64'd7, 64'd9, 1'b0, 0);
    chk_eq("add_after_abort", {cout_v[0], s_v[0]}, 65'd16);

    back_to_back(1);
    back_to_back(0);

    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < 10; i++) begin
        do_op(u, 2'($urandom), rand64(), rand64(), 1'($urandom), int'($urandom_range(0, 2)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
